// File: rtl/mac_array_tile_if.sv
// Operand/result bundle for mac_array_tile: input beat handshake,
// output FIFO handshake and status; master drives operands.
interface mac_array_tile_if #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int SW = $clog2(ACC_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_first;
  logic                          in_last;
  logic                          psum_use;
  logic [A_WIDTH-1:0]            a;
  logic [NUM_LANES*B_WIDTH-1:0]  b;
  logic [NUM_LANES*ACC_WIDTH-1:0] psum_in;
  logic [SW-1:0]                 out_shift;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_LANES*OUT_WIDTH-1:0] out_data;
  logic [NUM_LANES*ACC_WIDTH-1:0] out_acc;
  logic [NUM_LANES-1:0]          out_sat;
  logic [CW-1:0]                 fifo_count;
  logic                          busy;

  modport master (
    output in_valid, in_first, in_last, psum_use,
    output a, b, psum_in, out_shift, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_acc, out_sat, fifo_count, busy
  );

  modport slave (
    input  in_valid, in_first, in_last, psum_use,
    input  a, b, psum_in, out_shift, out_ready,
    output in_ready, out_valid, out_data,
    output out_acc, out_sat, fifo_count, busy
  );
endinterface

// File: rtl/mac_array_tile.sv
// Multi-lane MAC tile: capture, multiply, accumulate+requantize, output FIFO.
// Optional MAC_ARRAY_TILE_RELU_EN clamps negative out_data lanes to zero.
module mac_array_tile #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         arst_n_in,
  mac_array_tile_if.slave io
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int SW = $clog2(ACC_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int LB = NUM_LANES * B_WIDTH;
  localparam int LP = NUM_LANES * PW;
  localparam int LA = NUM_LANES * ACC_WIDTH;
  localparam int LO = NUM_LANES * OUT_WIDTH;
  localparam int XW = ACC_WIDTH + 1;

  localparam logic signed [XW-1:0] QMAX =
    {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] QMIN =
    {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic               v;
    logic               first;
    logic               last;
    logic               puse;
    logic [A_WIDTH-1:0] a;
    logic [LB-1:0]      b;
    logic [LA-1:0]      psum;
    logic [SW-1:0]      shift;
  } cap_stage_t;

  typedef struct packed {
    logic          v;
    logic          first;
    logic          last;
    logic          puse;
    logic [LP-1:0] prod;
    logic [LA-1:0] psum;
    logic [SW-1:0] shift;
  } mul_stage_t;

  cap_stage_t st0_q, st0_d;
  mul_stage_t st1_q, st1_d;

  logic [LA-1:0] acc_q, acc_d;
  logic          open_q, open_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [LO-1:0]        fifo_data_q [FIFO_DEPTH];
  logic [LA-1:0]        fifo_acc_q  [FIFO_DEPTH];
  logic [NUM_LANES-1:0] fifo_sat_q  [FIFO_DEPTH];

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        credit;
  logic [LO-1:0]        push_data;
  logic [LA-1:0]        push_acc;
  logic [NUM_LANES-1:0] push_sat;

  logic signed [PW-1:0]        ax, bx, p;
  logic signed [ACC_WIDTH-1:0] base, sum_acc;
  logic signed [XW-1:0]        ext, rnd, rsum, r;
  logic signed [OUT_WIDTH-1:0] qv;
  logic                        sat;

  // Credit counts results already committed to the FIFO path,
  // so a pop this cycle never feeds back into in_ready.
  assign credit = CW'(cnt_q)
                + CW'(st0_q.v & st0_q.last)
                + CW'(st1_q.v & st1_q.last);
  assign io.in_ready = credit < CW'(FIFO_DEPTH);
  assign accept      = io.in_valid & io.in_ready;

  always_comb begin
    st0_d   = st0_q;
    st0_d.v = accept;
    if (accept) begin
      st0_d.first = io.in_first;
      st0_d.last  = io.in_last;
      st0_d.puse  = io.psum_use;
      st0_d.a     = io.a;
      st0_d.b     = io.b;
      st0_d.psum  = io.psum_in;
      st0_d.shift = io.out_shift;
    end
  end

  always_comb begin
    st1_d.v     = st0_q.v;
    st1_d.first = st0_q.first;
    st1_d.last  = st0_q.last;
    st1_d.puse  = st0_q.puse;
    st1_d.psum  = st0_q.psum;
    st1_d.shift = st0_q.shift;
    st1_d.prod  = '0;
    ax = PW'($signed(st0_q.a));
    bx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bx = PW'($signed(st0_q.b[i*B_WIDTH +: B_WIDTH]));
      st1_d.prod[i*PW +: PW] = ax * bx;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    open_d    = open_q;
    push      = st1_q.v & st1_q.last;
    push_data = '0;
    push_acc  = '0;
    push_sat  = '0;
    p = '0; base = '0; sum_acc = '0;
    ext = '0; rnd = '0; rsum = '0; r = '0;
    qv = '0; sat = 1'b0;
    if (st1_q.v) open_d = !st1_q.last;
    for (int i = 0; i < NUM_LANES; i++) begin
      p = st1_q.prod[i*PW +: PW];
      if (st1_q.first)
        base = st1_q.puse ? st1_q.psum[i*ACC_WIDTH +: ACC_WIDTH] : '0;
      else
        base = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
      sum_acc = base + ACC_WIDTH'(p);
      if (st1_q.v)
        acc_d[i*ACC_WIDTH +: ACC_WIDTH] = st1_q.last ? '0 : sum_acc;
      // One extra bit keeps the half-LSB rounding add from wrapping.
      ext = XW'(sum_acc);
      rnd = '0;
      if (st1_q.shift != '0) rnd[st1_q.shift - SW'(1)] = 1'b1;
      rsum = ext + rnd;
      r    = rsum >>> st1_q.shift;
      if (r > QMAX) begin
        qv  = QMAX[OUT_WIDTH-1:0];
        sat = 1'b1;
      end else if (r < QMIN) begin
        qv  = QMIN[OUT_WIDTH-1:0];
        sat = 1'b1;
      end else begin
        qv  = r[OUT_WIDTH-1:0];
        sat = 1'b0;
      end
`ifdef MAC_ARRAY_TILE_RELU_EN
      if (qv[OUT_WIDTH-1]) qv = '0;
`endif
      push_data[i*OUT_WIDTH +: OUT_WIDTH] = qv;
      push_acc[i*ACC_WIDTH +: ACC_WIDTH]  = sum_acc;
      push_sat[i]                         = sat;
    end
  end

  assign pop = io.out_valid & io.out_ready;

  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      st0_q  <= '0;
      st1_q  <= '0;
      acc_q  <= '0;
      open_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      acc_q  <= acc_d;
      open_q <= open_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_q] <= push_data;
      fifo_acc_q[wr_q]  <= push_acc;
      fifo_sat_q[wr_q]  <= push_sat;
    end
  end

  assign io.out_valid  = cnt_q != '0;
  assign io.out_data   = io.out_valid ? fifo_data_q[rd_q] : '0;
  assign io.out_acc    = io.out_valid ? fifo_acc_q[rd_q] : '0;
  assign io.out_sat    = io.out_valid ? fifo_sat_q[rd_q] : '0;
  assign io.fifo_count = cnt_q;
  assign io.busy       = open_q | st0_q.v | st1_q.v;
endmodule

// File: tb/tb_mac_array_tile.sv
// Scoreboard bench for mac_array_tile: model results queued on accept,
// compared at the FIFO head every cycle it is valid.
module tb_mac_array_tile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_array_tile_if #(16, 16, 32, 16, 4, 4) io ();

  mac_array_tile #(
    .A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32),
    .OUT_WIDTH(16), .NUM_LANES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .arst_n_in(rst_n),
    .io(io)
  );

  typedef struct {
    logic [63:0]  data;
    logic [127:0] acc;
    logic [3:0]   sat;
  } exp_t;

  exp_t q[$];
  logic signed [31:0] macc [4];
  int n_tot = 0;
  int n_bad = 0;
  int n_acc = 0;
  bit stream_done;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] rq(input logic signed [31:0] acc,
                                     input int s);
    longint v;
    logic [16:0] res;
    v = longint'(acc);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 32767) res = {1'b1, 16'h7fff};
    else if (v < -32768) res = {1'b1, 16'h8000};
    else res = {1'b0, v[15:0]};
`ifdef MAC_ARRAY_TILE_RELU_EN
    if (res[15]) res[15:0] = 16'h0;
`endif
    return res;
  endfunction

  task automatic model(input bit f, input bit l, input bit pu,
                       input logic [15:0] av, input logic [63:0] bv,
                       input logic [127:0] pv, input logic [4:0] sh);
    exp_t e;
    logic [16:0] r;
    for (int i = 0; i < 4; i++) begin
      logic signed [31:0] pr, bs;
      pr = 32'($signed(av)) * 32'($signed(bv[i*16 +: 16]));
      if (f) bs = pu ? $signed(pv[i*32 +: 32]) : 32'sd0;
      else bs = macc[i];
      macc[i] = bs + pr;
    end
    if (l) begin
      for (int i = 0; i < 4; i++) begin
        r = rq(macc[i], int'(sh));
        e.data[i*16 +: 16] = r[15:0];
        e.sat[i] = r[16];
        e.acc[i*32 +: 32] = macc[i];
        macc[i] = 0;
      end
      q.push_back(e);
    end
  endtask

  task automatic send(input bit f, input bit l, input bit pu,
                      input logic [15:0] av, input logic [63:0] bv,
                      input logic [127:0] pv, input logic [4:0] sh);
    int n;
    io.in_valid = 1'b1;
    io.in_first = f;
    io.in_last = l;
    io.psum_use = pu;
    io.a = av;
    io.b = bv;
    io.psum_in = pv;
    io.out_shift = sh;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) chk("accept_timeout", io.in_ready, 1);
    @(posedge clk);
    model(f, l, pu, av, bv, pv, sh);
    n_acc++;
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", io.out_valid, 1);
  endtask

  task automatic drain();
    int n;
    io.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 0);
    cyc(1);
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 4; i++) macc[i] = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", q.size(), 1);
      end else begin
        chk("head_data", io.out_data, q[0].data);
        chk("head_acc", io.out_acc, q[0].acc);
        chk("head_sat", io.out_sat, q[0].sat);
        if (io.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", n_tot);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] bv;
    logic [127:0] pv;
    int nb;
    io.in_valid = 0; io.in_first = 0; io.in_last = 0;
    io.psum_use = 0; io.a = '0; io.b = '0;
    io.psum_in = '0; io.out_shift = '0; io.out_ready = 0;
    clear_model();

    cyc(2);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_count", io.fifo_count, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_data", io.out_data, 0);
    chk("rst_acc", io.out_acc, 0);
    chk("rst_sat", io.out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", io.in_ready, 1);
    cyc(1);

    // single beat, latency check
    send(1, 1, 0, 16'd3, {16'd5, 16'd4, 16'hfffe, 16'd1}, '0, 5'd0);
    @(negedge clk);
    chk("lat_busy", io.busy, 1);
    @(negedge clk);
    chk("lat_t1", io.out_valid, 0);
    @(negedge clk);
    chk("lat_t2", io.out_valid, 1);
    chk("t1_data", io.out_data, {16'd15, 16'd12, 16'hfffa, 16'd3});
    chk("t1_sat", io.out_sat, 0);
    drain();
    io.out_ready = 0;

    // three-beat accumulation
    pv = {4{32'd100}};
    bv = {4{16'd10}};
    send(1, 0, 1, 16'd2, bv, pv, 5'd2);
    send(0, 0, 1, 16'd2, bv, pv, 5'd2);
    send(0, 1, 1, 16'd2, bv, pv, 5'd2);
    cyc(4);
    chk("t3_count", io.fifo_count, 1);
    chk("t3_data", io.out_data, {4{16'd40}});
    chk("t3_acc", io.out_acc, {4{32'd160}});
    drain();
    io.out_ready = 0;

    // rounding / saturation boundaries
    pv = {32'd6, -32'sd70000, 32'h00018000, 32'h00007fff};
    send(1, 1, 1, 16'd0, 64'd0, pv, 5'd0);
    wait_valid();
    chk("t4_data", io.out_data, {16'd6, 16'h8000, 16'h7fff, 16'h7fff});
    chk("t4_sat", io.out_sat, 4'b0110);
    drain();
    io.out_ready = 0;
    send(1, 1, 1, 16'd0, 64'd0, {4{32'd6}}, 5'd2);
    wait_valid();
    chk("t4_round", io.out_data, {4{16'd2}});
    drain();
    io.out_ready = 0;

    // backpressure: six results into a four-entry FIFO
    n_acc = 0;
    fork
      for (int k = 0; k < 6; k++)
        send(1, 1, 0, 16'(k + 1), {16'd1, 16'hffff, 16'd2, 16'd7},
             '0, 5'd0);
    join_none
    cyc(20);
    chk("bp_accepted", n_acc, 4);
    chk("bp_count", io.fifo_count, 4);
    chk("bp_ready", io.in_ready, 0);
    io.out_ready = 1;
    wait fork;
    drain();
    chk("bp_total", n_acc, 6);

    // random streaming with random consumer stalls
    stream_done = 0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          nb = $urandom_range(1, 3);
          for (int j = 0; j < nb; j++) begin
            bv = {$urandom(), $urandom()};
            pv = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(j == 0, j == nb - 1, 1'($urandom_range(0, 1)),
                 16'($urandom()), bv, pv, 5'($urandom_range(0, 31)));
          end
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          io.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    io.out_ready = 0;

    // reset mid-accumulation with queued results
    send(1, 1, 0, 16'd9, {4{16'd9}}, '0, 5'd0);
    send(1, 1, 0, 16'd8, {4{16'd8}}, '0, 5'd0);
    send(1, 0, 0, 16'd100, {4{16'd100}}, '0, 5'd0);
    send(0, 0, 0, 16'd100, {4{16'd100}}, '0, 5'd0);
    cyc(3);
    chk("mr_count_pre", io.fifo_count, 2);
    chk("mr_busy_pre", io.busy, 1);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("mr_valid", io.out_valid, 0);
    chk("mr_count", io.fifo_count, 0);
    chk("mr_busy", io.busy, 0);
    chk("mr_data", io.out_data, 0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready", io.in_ready, 1);
    cyc(1);
    send(0, 1, 0, 16'd5, {16'd4, 16'd3, 16'd2, 16'd1}, '0, 5'd0);
    wait_valid();
    chk("mr_new", io.out_data, {16'd20, 16'd15, 16'd10, 16'd5});
    chk("mr_new_acc", io.out_acc, {32'd20, 32'd15, 32'd10, 32'd5});
    drain();
    chk("final_count", io.fifo_count, 0);
    chk("final_busy", io.busy, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
